// File: rtl/ysyx_22050710_lsu_pkg.sv
// Shared encodings for the MEM-stage load/store controller: access ops,
// access-size field values and controller states.
package ysyx_22050710_lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_BU = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_HU = 3'b011;
  localparam logic [2:0] OP_W  = 3'b100;
  localparam logic [2:0] OP_WU = 3'b101;
  localparam logic [2:0] OP_D  = 3'b110;

  // op[2:1] carries the access size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    size_mask = 8'h01;
      SZ_H:    size_mask = 8'h03;
      SZ_W:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050710_lsu_store_mask.sv
// Byte-lane placement for an access: write strobe, lane-shifted store data
// and the natural-alignment check.
module ysyx_22050710_lsu_store_mask
  import ysyx_22050710_lsu_pkg::*;
#(
  parameter int WORD_WD = 64
) (
  input  logic [1:0]         i_size,
  input  logic [2:0]         i_off,
  input  logic [WORD_WD-1:0] i_wdata,
  output logic [7:0]         o_wstrb,
  output logic [WORD_WD-1:0] o_wdata,
  output logic               o_misalign
);

  logic [7:0] w_mask;

  assign w_mask  = size_mask(i_size);
  assign o_wstrb = w_mask << i_off;
  assign o_wdata = i_wdata << {i_off, 3'b000};

  always_comb begin
    o_misalign = 1'b0;
    case (i_size)
      SZ_B:    o_misalign = 1'b0;
      SZ_H:    o_misalign = i_off[0];
      SZ_W:    o_misalign = |i_off[1:0];
      default: o_misalign = |i_off;
    endcase
  end

endmodule

// File: rtl/ysyx_22050710_lsu_ctrl.sv
// MEM-stage load/store sequencer: one operation at a time, one aligned
// doubleword request on the data-SRAM bus, extended load data on completion.
module ysyx_22050710_lsu_ctrl
  import ysyx_22050710_lsu_pkg::*;
#(
  parameter int WORD_WD      = 64,
  parameter int ADDR_WD      = 32,
  parameter int SRAM_DATA_WD = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic                    i_wen,
  input  logic [2:0]              i_mem_op,
  input  logic [ADDR_WD-1:0]      i_addr,
  input  logic [WORD_WD-1:0]      i_wdata,
  output logic                    o_busy,
  output logic                    o_req_valid,
  input  logic                    i_req_ready,
  output logic [ADDR_WD-1:0]      o_req_addr,
  output logic                    o_req_wen,
  output logic [SRAM_DATA_WD-1:0] o_req_wdata,
  output logic [7:0]              o_req_wstrb,
  input  logic                    i_resp_valid,
  output logic                    o_resp_ready,
  input  logic [SRAM_DATA_WD-1:0] i_resp_rdata,
  input  logic                    i_resp_err,
  output logic                    o_done,
  output logic [WORD_WD-1:0]      o_rdata,
  output logic                    o_misalign,
  output logic                    o_fault
);

  lsu_state_e r_state, w_next;

  logic                    r_wen;
  logic [2:0]              r_op;
  logic [2:0]              r_off;
  logic [ADDR_WD-1:0]      r_addr;
  logic [SRAM_DATA_WD-1:0] r_wdata;
  logic [7:0]              r_wstrb;
  logic [WORD_WD-1:0]      r_rdata;
  logic                    r_mis;
  logic                    r_flt;

  logic [7:0]              w_wstrb;
  logic [SRAM_DATA_WD-1:0] w_wdata;
  logic                    w_mis;
  logic                    w_accept;
  logic                    w_resp;
  logic [WORD_WD-1:0]      w_shift;
  logic [WORD_WD-1:0]      w_ext;

  ysyx_22050710_lsu_store_mask #(.WORD_WD(SRAM_DATA_WD)) u_mask (
    .i_size     (i_mem_op[2:1]),
    .i_off      (i_addr[2:0]),
    .i_wdata    (i_wdata),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_wdata),
    .o_misalign (w_mis)
  );

  assign w_accept = (r_state == S_IDLE) && i_valid;
  assign w_resp   = (r_state == S_WAIT) && i_resp_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_valid)      w_next = w_mis ? S_DONE : S_REQ;
      S_REQ:  if (i_req_ready)  w_next = S_WAIT;
      S_WAIT: if (i_resp_valid) w_next = S_DONE;
      S_DONE:                   w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // Right-justify the addressed lane, then extend per op; 111 behaves as ld.
  assign w_shift = i_resp_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shift;
    case (r_op)
      OP_B:    w_ext = {{(WORD_WD-8){w_shift[7]}},   w_shift[7:0]};
      OP_BU:   w_ext = {{(WORD_WD-8){1'b0}},         w_shift[7:0]};
      OP_H:    w_ext = {{(WORD_WD-16){w_shift[15]}}, w_shift[15:0]};
      OP_HU:   w_ext = {{(WORD_WD-16){1'b0}},        w_shift[15:0]};
      OP_W:    w_ext = {{(WORD_WD-32){w_shift[31]}}, w_shift[31:0]};
      OP_WU:   w_ext = {{(WORD_WD-32){1'b0}},        w_shift[31:0]};
      default: w_ext = w_shift;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_wen   <= 1'b0;
      r_op    <= '0;
      r_off   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_mis   <= 1'b0;
      r_flt   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wen   <= i_wen;
        r_op    <= i_mem_op;
        r_off   <= i_addr[2:0];
        r_addr  <= {i_addr[ADDR_WD-1:3], 3'b000};
        r_wdata <= w_wdata;
        r_wstrb <= w_wstrb;
        r_rdata <= '0;
        r_mis   <= w_mis;
        r_flt   <= 1'b0;
      end
      if (w_resp) begin
        r_flt   <= i_resp_err;
        r_rdata <= (i_resp_err || r_wen) ? '0 : w_ext;
      end
    end
  end

  assign o_busy       = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;
  assign o_req_valid  = (r_state == S_REQ);
  assign o_resp_ready = (r_state == S_WAIT);
  assign o_req_addr   = r_addr;
  assign o_req_wen    = r_wen;
  assign o_req_wdata  = r_wdata;
  assign o_req_wstrb  = r_wstrb;
  assign o_done       = (r_state == S_DONE);
  assign o_rdata      = o_done ? r_rdata : '0;
  assign o_misalign   = o_done & r_mis;
  assign o_fault      = o_done & r_flt;

endmodule
